return_addr_stack: RTL and testbench
====================================

Name: return_addr_stack

Overview:
Parametrised return-address stack predicting jalr targets in the instruction queue; the next generation of the 16-entry call stack.
- Adds configurable depth/width and combined pop+push (coroutine-style jalr).
- Adds a saturating occupancy count with explicit empty/overflow signalling.
- Adds a checkpoint file so a branch-mispredict flush can repair the stack pointer and the top entry.

Parameters:
ADDR_W, 17, width of a stored return address
DEPTH, 16, number of stack entries; power of 2, >=2
NCKPT, 4, number of checkpoint slots; power of 2, >=1

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset; state cleared while rst==0
op_push  in  1  push push_addr (call)
op_pop  in  1  pop (return); op_push&op_pop = replace top
push_addr  in  ADDR_W  return address to push
top_addr  out  ADDR_W  current top entry (prediction), combinational from state
top_valid  out  1  count!=0
ovf_pulse  out  1  registered; 1 cycle after a push that overwrote the oldest entry
udf_pulse  out  1  registered; 1 cycle after a pop on empty
ckpt_save  in  1  snapshot current state into slot ckpt_id
ckpt_restore  in  1  restore state from slot ckpt_id (flush)
ckpt_id  in  $clog2(NCKPT) (min 1)  slot index

Behaviour:
- State: mem[DEPTH], ptr (log2 DEPTH bits, points at top entry), count (0..DEPTH).
- Reset (async, rst low): ptr=0, count=0, every mem entry=0, every checkpoint slot zeroed, ovf_pulse=0, udf_pulse=0. Outputs: top_addr=0, top_valid=0.
- top_addr = mem[ptr] always; a pop in cycle N uses the top_addr visible in cycle N; its effect is visible in N+1.
- Push only: ptr<=ptr+1 (wraps mod DEPTH); mem[ptr+1]<=push_addr.
  - count<DEPTH: count<=count+1.
  - count==DEPTH: oldest entry overwritten; count stays DEPTH; ovf_pulse=1 next cycle.
- Pop only:
  - count>0: ptr<=ptr-1 (wraps); count<=count-1.
  - count==0: no state change; udf_pulse=1 next cycle.
- Push+pop: mem[ptr]<=push_addr; ptr unchanged; count<=max(count,1); no pulses.
- ckpt_save: slot[ckpt_id] <= {ptr, count, mem[ptr]}, sampled before the same-cycle op; a save in the same cycle as an op is legal.
- ckpt_restore: ptr<=slot.ptr; count<=slot.count; mem[slot.ptr]<=slot.top.
  - Overrides any same-cycle op and save; those are dropped and no pulses fire.
- Pulses are 1-cycle registered flags, cleared every cycle otherwise.
- Entries below ptr that were overwritten after a save are not repaired; this prediction inaccuracy is permitted.

Optional Feature:
Macro RAS_STATS_EN.
- Defined: adds outputs ovf_cnt[15:0] and udf_cnt[15:0].
  - Each increments on ovf_pulse / udf_pulse respectively and saturates at 16'hFFFF.
  - Reset to 0 asynchronously; not affected by restore.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package ras_pkg holds:
  - Default constants RAS_ADDR_W=17, RAS_DEPTH=16, RAS_NCKPT=4.
  - Checkpoint record typedef ras_ckpt_t {ptr, count, top}, parametrised through package localparams.
- One sub-module: ras_ckpt_file.
  - NCKPT-entry register file with one write port (save) and one read port (restore), async active-low reset.
- Stack array and pointer logic stay in return_addr_stack.

Test Plan:
1. Reset, then push 0x00100, 0x00200 -> top_addr=0x00200, top_valid=1; pop -> next cycle top_addr=0x00100; pop -> top_valid=0.
2. DEPTH=16: push 17 addresses 1..17 -> ovf_pulse high exactly once (cycle after 17th push), count=16; 16 pops return 17..2 in order, then top_valid=0.
3. Empty stack, pop -> udf_pulse=1 for one cycle, ptr/count unchanged, top_valid stays 0; with RAS_STATS_EN, udf_cnt=1.
4. Push 0x00A00, then push+pop with 0x00B00 -> top_addr=0x00B00, count=1; single pop -> top_valid=0.
5. Push 0x00111; save slot 2; push 0x00222, pop, pop, push 0x00333 (overwrites the 0x00111 entry); restore slot 2 -> top_addr=0x00111, count=1.
6. Restore asserted together with push 0x0FFFF on a full stack -> push dropped, no ovf_pulse, state equals saved slot. Also assert rst low mid-sequence -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ras_pkg.sv
// ras_pkg: shared constants, checkpoint record and helpers for the return-address stack
package ras_pkg;
  localparam int RAS_ADDR_W = 17;
  localparam int RAS_DEPTH = 16;
  localparam int RAS_NCKPT = 4;
  localparam int RAS_PTR_W = $clog2(RAS_DEPTH);
  localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);
  typedef struct packed {
    logic [RAS_PTR_W-1:0] ptr;
    logic [RAS_CNT_W-1:0] count;
    logic [RAS_ADDR_W-1:0] top;
  } ras_ckpt_t;
  function automatic int ckpt_idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/return_addr_stack_if.sv
// return_addr_stack_if: op/checkpoint/prediction bundle between an instruction queue and the stack
// master drives op_push, op_pop, push_addr, ckpt_save, ckpt_restore, ckpt_id
// slave drives top_addr, top_valid, ovf_pulse, udf_pulse (and ovf_cnt/udf_cnt with RAS_STATS_EN)
interface return_addr_stack_if import ras_pkg::*; #(
  parameter int ADDR_W = RAS_ADDR_W,
  parameter int NCKPT = RAS_NCKPT
) ();
  localparam int IW = ckpt_idx_w(NCKPT);
  logic op_push, op_pop, ckpt_save, ckpt_restore;
  logic [ADDR_W-1:0] push_addr, top_addr;
  logic [IW-1:0] ckpt_id;
  logic top_valid, ovf_pulse, udf_pulse;
`ifdef RAS_STATS_EN
  logic [15:0] ovf_cnt, udf_cnt;
  modport master (output op_push, op_pop, push_addr, ckpt_save, ckpt_restore, ckpt_id,
                  input top_addr, top_valid, ovf_pulse, udf_pulse, ovf_cnt, udf_cnt);
  modport slave (input op_push, op_pop, push_addr, ckpt_save, ckpt_restore, ckpt_id,
                 output top_addr, top_valid, ovf_pulse, udf_pulse, ovf_cnt, udf_cnt);
`else
  modport master (output op_push, op_pop, push_addr, ckpt_save, ckpt_restore, ckpt_id,
                  input top_addr, top_valid, ovf_pulse, udf_pulse);
  modport slave (input op_push, op_pop, push_addr, ckpt_save, ckpt_restore, ckpt_id,
                 output top_addr, top_valid, ovf_pulse, udf_pulse);
`endif
endinterface

// File: rtl/ras_ckpt_file.sv
// ras_ckpt_file: N-slot checkpoint register file, one save write port and one restore read port
// ports: clk, rst (async active-low), we/wa/wd save port, ra/rd combinational restore port
module ras_ckpt_file import ras_pkg::*; #(
  parameter int W = 8,
  parameter int N = RAS_NCKPT,
  localparam int IW = ckpt_idx_w(N)
) (
  input logic clk,
  input logic rst,
  input logic we,
  input logic [IW-1:0] wa,
  input logic [W-1:0] wd,
  input logic [IW-1:0] ra,
  output logic [W-1:0] rd
);
  logic [W-1:0] slot [N];
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < N; i++) slot[i] <= '0;
    else if (we) slot[wa] <= wd;
  assign rd = slot[ra];
endmodule

// File: rtl/return_addr_stack.sv
// return_addr_stack: checkpointed return-address stack predicting jalr targets
// ports: clk, rst (async active-low), bus (return_addr_stack_if.slave)
// optional: RAS_STATS_EN adds saturating ovf_cnt/udf_cnt event counters on bus
module return_addr_stack import ras_pkg::*; #(
  parameter int ADDR_W = RAS_ADDR_W,
  parameter int DEPTH = RAS_DEPTH,
  parameter int NCKPT = RAS_NCKPT
) (
  input logic clk,
  input logic rst,
  return_addr_stack_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  typedef struct packed {
    logic [PW-1:0] ptr;
    logic [CW-1:0] count;
    logic [ADDR_W-1:0] top;
  } ckpt_t;
  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0] ptr, ptr_inc, ptr_dec;
  logic [CW-1:0] count;
  logic full, empty, ovf, udf;
  ckpt_t save_rec, rest_rec;
  assign ptr_inc = ptr + 1'b1;
  assign ptr_dec = ptr - 1'b1;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign save_rec = '{ptr: ptr, count: count, top: mem[ptr]};
  // a restore wins over a same-cycle save, so the slot being restored is never clobbered
  ras_ckpt_file #(.W($bits(ckpt_t)), .N(NCKPT)) u_ckpt (
    .clk(clk),
    .rst(rst),
    .we(bus.ckpt_save & ~bus.ckpt_restore),
    .wa(bus.ckpt_id),
    .wd(save_rec),
    .ra(bus.ckpt_id),
    .rd(rest_rec)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      ptr <= '0;
      count <= '0;
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= 1'b0;
      udf <= 1'b0;
      if (bus.ckpt_restore) begin
        ptr <= rest_rec.ptr;
        count <= rest_rec.count;
        mem[rest_rec.ptr] <= rest_rec.top;
      end else if (bus.op_push && bus.op_pop) begin
        mem[ptr] <= bus.push_addr;
        if (empty) count <= CW'(1);
      end else if (bus.op_push) begin
        ptr <= ptr_inc;
        mem[ptr_inc] <= bus.push_addr;
        if (full) ovf <= 1'b1;
        else count <= count + 1'b1;
      end else if (bus.op_pop) begin
        if (empty) udf <= 1'b1;
        else begin
          ptr <= ptr_dec;
          count <= count - 1'b1;
        end
      end
    end
  assign bus.top_addr = mem[ptr];
  assign bus.top_valid = !empty;
  assign bus.ovf_pulse = ovf;
  assign bus.udf_pulse = udf;
`ifdef RAS_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.ovf_cnt <= '0;
      bus.udf_cnt <= '0;
    end else begin
      if (ovf && bus.ovf_cnt != 16'hFFFF) bus.ovf_cnt <= bus.ovf_cnt + 1'b1;
      if (udf && bus.udf_cnt != 16'hFFFF) bus.udf_cnt <= bus.udf_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_return_addr_stack.sv
// tb_return_addr_stack: directed and random checks of return_addr_stack against a behavioural model
module tb_return_addr_stack;
  import ras_pkg::*;
  localparam int D = 16;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  return_addr_stack_if #(.ADDR_W(17), .NCKPT(4)) bus ();
  return_addr_stack #(.ADDR_W(17), .DEPTH(D), .NCKPT(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [16:0] m [D];
  int p, c;
  bit e_ovf, e_udf;
  int e_ocnt, e_ucnt;
  ras_ckpt_t sl [4];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    for (int i = 0; i < D; i++) m[i] = '0;
    for (int i = 0; i < 4; i++) sl[i] = '0;
    p = 0; c = 0; e_ovf = 0; e_udf = 0; e_ocnt = 0; e_ucnt = 0;
  endtask
  task automatic model_step(input bit pu, input bit po, input logic [16:0] a,
                            input bit sv, input bit rs, input int id);
    if (e_ovf && e_ocnt < 65535) e_ocnt++;
    if (e_udf && e_ucnt < 65535) e_ucnt++;
    e_ovf = 0; e_udf = 0;
    if (rs) begin
      p = int'(sl[id].ptr); c = int'(sl[id].count); m[p] = sl[id].top;
    end else begin
      if (sv) sl[id] = '{ptr: 4'(p), count: 5'(c), top: m[p]};
      if (pu && po) begin
        m[p] = a;
        if (c == 0) c = 1;
      end else if (pu) begin
        p = (p + 1) % D; m[p] = a;
        if (c == D) e_ovf = 1; else c++;
      end else if (po) begin
        if (c == 0) e_udf = 1;
        else begin p = (p + D - 1) % D; c--; end
      end
    end
  endtask
  task automatic check_all(input string tag);
    chk({tag, " top_addr"}, 32'(bus.top_addr), 32'(m[p]));
    chk({tag, " top_valid"}, 32'(bus.top_valid), 32'(c != 0));
    chk({tag, " ovf_pulse"}, 32'(bus.ovf_pulse), 32'(e_ovf));
    chk({tag, " udf_pulse"}, 32'(bus.udf_pulse), 32'(e_udf));
`ifdef RAS_STATS_EN
    chk({tag, " ovf_cnt"}, 32'(bus.ovf_cnt), 32'(e_ocnt));
    chk({tag, " udf_cnt"}, 32'(bus.udf_cnt), 32'(e_ucnt));
`endif
  endtask
  task automatic idle_inputs();
    bus.op_push = 0; bus.op_pop = 0; bus.push_addr = '0;
    bus.ckpt_save = 0; bus.ckpt_restore = 0; bus.ckpt_id = '0;
  endtask
  task automatic cyc(input string tag, input bit pu, input bit po, input logic [16:0] a,
                     input bit sv, input bit rs, input int id);
    bus.op_push = pu; bus.op_pop = po; bus.push_addr = a;
    bus.ckpt_save = sv; bus.ckpt_restore = rs; bus.ckpt_id = 2'(id);
    @(posedge clk);
    model_step(pu, po, a, sv, rs, id);
    #1;
    idle_inputs();
    check_all(tag);
  endtask
  task automatic push(input string tag, input logic [16:0] a); cyc(tag, 1, 0, a, 0, 0, 0); endtask
  task automatic pop(input string tag); cyc(tag, 0, 1, '0, 0, 0, 0); endtask
  task automatic expect_top(input string tag, input logic [16:0] a, input bit v);
    chk({tag, " const top_addr"}, 32'(bus.top_addr), 32'(a));
    chk({tag, " const top_valid"}, 32'(bus.top_valid), 32'(v));
  endtask
  task automatic do_reset(input string tag);
    rst = 0;
    #2;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int ovf_seen;
    idle_inputs();
    #3;
    do_reset("reset");
    expect_top("reset", 17'h0, 0);
    push("t1 push1", 17'h00100);
    push("t1 push2", 17'h00200);
    expect_top("t1 after push", 17'h00200, 1);
    pop("t1 pop1");
    expect_top("t1 after pop", 17'h00100, 1);
    pop("t1 pop2");
    chk("t1 empty valid", 32'(bus.top_valid), 32'(0));
    do_reset("t2 reset");
    ovf_seen = 0;
    for (int i = 1; i <= 17; i++) begin
      push("t2 fill", 17'(i));
      ovf_seen += int'(bus.ovf_pulse);
    end
    chk("t2 ovf after 17th push", 32'(bus.ovf_pulse), 32'(1));
    pop("t2 pop first");
    ovf_seen += int'(bus.ovf_pulse);
    chk("t2 ovf count", 32'(ovf_seen), 32'(1));
    for (int i = 16; i >= 3; i--) begin
      expect_top("t2 drain", 17'(i), 1);
      pop("t2 drain");
    end
    expect_top("t2 last", 17'd2, 1);
    pop("t2 pop last");
    chk("t2 empty valid", 32'(bus.top_valid), 32'(0));
    do_reset("t3 reset");
    pop("t3 underflow");
    chk("t3 udf", 32'(bus.udf_pulse), 32'(1));
    cyc("t3 idle", 0, 0, '0, 0, 0, 0);
    chk("t3 udf cleared", 32'(bus.udf_pulse), 32'(0));
`ifdef RAS_STATS_EN
    chk("t3 udf_cnt", 32'(bus.udf_cnt), 32'(1));
`endif
    do_reset("t4 reset");
    push("t4 push", 17'h00A00);
    cyc("t4 replace", 1, 1, 17'h00B00, 0, 0, 0);
    expect_top("t4 replace", 17'h00B00, 1);
    pop("t4 pop");
    chk("t4 empty valid", 32'(bus.top_valid), 32'(0));
    do_reset("t5 reset");
    push("t5 push111", 17'h00111);
    cyc("t5 save", 0, 0, '0, 1, 0, 2);
    push("t5 push222", 17'h00222);
    pop("t5 pop");
    pop("t5 pop");
    push("t5 push333", 17'h00333);
    cyc("t5 restore", 0, 0, '0, 0, 1, 2);
    expect_top("t5 restored", 17'h00111, 1);
    pop("t5 pop restored");
    chk("t5 count was 1", 32'(bus.top_valid), 32'(0));
    do_reset("t6 reset");
    push("t6 push", 17'h00AAA);
    cyc("t6 save", 0, 0, '0, 1, 0, 1);
    for (int i = 0; i < 16; i++) push("t6 fill", 17'(17'h01000 + i));
    cyc("t6 restore+push", 1, 0, 17'h0FFFF, 1, 1, 1);
    chk("t6 no ovf", 32'(bus.ovf_pulse), 32'(0));
    expect_top("t6 restored", 17'h00AAA, 1);
    push("t6 push again", 17'h00555);
    #2;
    rst = 0;
    #1;
    chk("t6 async top_addr", 32'(bus.top_addr), 32'(0));
    chk("t6 async top_valid", 32'(bus.top_valid), 32'(0));
    chk("t6 async ovf", 32'(bus.ovf_pulse), 32'(0));
    chk("t6 async udf", 32'(bus.udf_pulse), 32'(0));
    model_reset();
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    #1;
    check_all("t6 after reset");
    for (int i = 0; i < 600; i++) begin
      int r;
      bit pu, po, sv, rs;
      r = int'($urandom_range(0, 99));
      pu = r < 45 || (r >= 85 && r < 90);
      po = (r >= 45 && r < 80) || (r >= 85 && r < 90);
      sv = $urandom_range(0, 9) == 0;
      rs = $urandom_range(0, 14) == 0;
      cyc("rand", pu, po, 17'($urandom_range(0, 17'h1FFFF)), sv, rs, int'($urandom_range(0, 3)));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
